// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch buffer between the pc block and decode.
// Issues word requests over req/gnt/rvalid and tracks each granted address
// in an address FIFO. Returned words go into an in-order {pc, instr} FIFO,
// which decode drains through a valid/ready handshake.
// A flush clears the buffer. If requests are still outstanding, the block
// enters DRAIN and discards their responses before it fetches again.
// Optional macro IFETCH_PERF_EN adds the PERF_STALL and PERF_FLUSH
// saturating event counters.
module ifetch_buf #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [XLEN-1:0] IP,
    output logic            FETCH_ADV,
    input  logic            FLUSH,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_GNT,
    input  logic            IMEM_RVALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic            INSTR_VALID,
    input  logic            INSTR_READY,
    output logic [XLEN-1:0] INSTR,
    output logic [XLEN-1:0] INSTR_PC,
    output logic [6:0]      OP
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     PERF_STALL,
    output logic [31:0]     PERF_FLUSH
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   a_wp_r, a_rp_r, i_wp_r, i_rp_r;
    logic [XLEN-1:0] addr_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [CW-1:0]   occ_r, out_cnt_r, drop_cnt_r;
    logic [CW-1:0]   out_cnt_nxt_s, drop_cnt_nxt_s;
    logic [CW:0]     inflight_s;
    logic            space_s, req_s, gnt_s, rsp_s, push_s, pop_s, valid_s, clear_s;

    // Handshake qualification and the outstanding-request count for next cycle
    always_comb begin
        inflight_s = {1'b0, occ_r} + {1'b0, out_cnt_r};
        space_s    = inflight_s < (CW+1)'(DEPTH);
        gnt_s      = req_s && IMEM_GNT;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_s      = IMEM_RVALID && (out_cnt_r != {CW{1'b0}});
        clear_s    = (state_r == RUN) && FLUSH;
        pop_s      = valid_s && INSTR_READY && !FLUSH;
        // A pop in the same cycle frees a slot for the incoming word.
        push_s     = rsp_s && (state_r == RUN) && !FLUSH &&
                     ((occ_r < CW'(DEPTH)) || pop_s);
        if (gnt_s && !rsp_s) begin
            out_cnt_nxt_s = out_cnt_r + 1'b1;
        end else if (!gnt_s && rsp_s) begin
            out_cnt_nxt_s = out_cnt_r - 1'b1;
        end else begin
            out_cnt_nxt_s = out_cnt_r;
        end
    end

    // FSM state and drop-counter register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r    <= RUN;
            drop_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    // FSM next state: a flush with requests still in flight enters DRAIN
    always_comb begin
        state_nxt_s    = state_r;
        drop_cnt_nxt_s = drop_cnt_r;
        case (state_r)
            RUN: begin
                if (FLUSH && (out_cnt_nxt_s != {CW{1'b0}})) begin
                    state_nxt_s    = DRAIN;
                    drop_cnt_nxt_s = out_cnt_nxt_s;
                end else begin
                    state_nxt_s    = RUN;
                end
            end
            DRAIN: begin
                if (rsp_s) begin
                    drop_cnt_nxt_s = drop_cnt_r - 1'b1;
                    if (drop_cnt_r == CW'(1'b1)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s    = RUN;
                drop_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // FSM outputs: request only in RUN with room, and never while held in reset
    always_comb begin
        req_s   = RESET_N && (state_r == RUN) && !FLUSH && space_s;
        valid_s = (state_r == RUN) && (occ_r != {CW{1'b0}});
    end

    // Pointers, occupancy and the outstanding count
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            a_wp_r    <= {AW{1'b0}};
            a_rp_r    <= {AW{1'b0}};
            i_wp_r    <= {AW{1'b0}};
            i_rp_r    <= {AW{1'b0}};
            occ_r     <= {CW{1'b0}};
            out_cnt_r <= {CW{1'b0}};
        end else begin
            out_cnt_r <= out_cnt_nxt_s;
            if (gnt_s) begin
                a_wp_r <= a_wp_r + 1'b1;
            end
            if (rsp_s) begin
                a_rp_r <= a_rp_r + 1'b1;
            end
            if (clear_s) begin
                i_wp_r <= {AW{1'b0}};
                i_rp_r <= {AW{1'b0}};
                occ_r  <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    i_wp_r <= i_wp_r + 1'b1;
                end
                if (pop_s) begin
                    i_rp_r <= i_rp_r + 1'b1;
                end
                if (push_s && !pop_s) begin
                    occ_r <= occ_r + 1'b1;
                end else if (pop_s && !push_s) begin
                    occ_r <= occ_r - 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge CLK) begin
        if (gnt_s) begin
            addr_mem_r[a_wp_r] <= IP;
        end
        if (push_s && !clear_s) begin
            pc_mem_r[i_wp_r]   <= addr_mem_r[a_rp_r];
            data_mem_r[i_wp_r] <= IMEM_RDATA;
        end
    end

    // Output drive; an empty buffer presents zeros and the NOP opcode
    always_comb begin
        IMEM_REQ    = req_s;
        IMEM_ADDR   = IP;
        FETCH_ADV   = gnt_s;
        INSTR_VALID = valid_s;
        if (valid_s) begin
            INSTR    = data_mem_r[i_rp_r];
            INSTR_PC = pc_mem_r[i_rp_r];
            OP       = data_mem_r[i_rp_r][6:0];
        end else begin
            INSTR    = {XLEN{1'b0}};
            INSTR_PC = {XLEN{1'b0}};
            OP       = 7'b0010011;
        end
    end

`ifdef IFETCH_PERF_EN
    // Saturating stall and flush event counters
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            PERF_STALL <= 32'h0000_0000;
            PERF_FLUSH <= 32'h0000_0000;
        end else begin
            if ((state_r == RUN) && !req_s && (PERF_STALL != 32'hFFFF_FFFF)) begin
                PERF_STALL <= PERF_STALL + 32'h0000_0001;
            end
            if (clear_s && (PERF_FLUSH != 32'hFFFF_FFFF)) begin
                PERF_FLUSH <= PERF_FLUSH + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed bench for ifetch_buf (DEPTH=2, XLEN=32).
// The bench acts as both the pc block and the instruction memory. It keeps
// a reference queue of granted addresses and a scoreboard of expected
// {pc, instr} entries, and checks the DUT outputs every cycle.
module tb_ifetch_buf;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [XLEN-1:0] IP = 32'h0;
    logic            FETCH_ADV;
    logic            FLUSH = 1'b0;
    logic            IMEM_REQ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_GNT = 1'b0;
    logic            IMEM_RVALID = 1'b0;
    logic [XLEN-1:0] IMEM_RDATA = 32'h0;
    logic            INSTR_VALID;
    logic            INSTR_READY = 1'b0;
    logic [XLEN-1:0] INSTR;
    logic [XLEN-1:0] INSTR_PC;
    logic [6:0]      OP;

    int          checks = 0;
    int          errors = 0;
    int          adv_cnt = 0;
    logic [31:0] gq[$];
    logic [63:0] exp_q[$];
    logic [31:0] pc_log[$];
    bit          draining = 1'b0;
    int          drop_n = 0;
    int          adv_before;

    ifetch_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IP(IP), .FETCH_ADV(FETCH_ADV),
        .FLUSH(FLUSH), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .INSTR_PC(INSTR_PC), .OP(OP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[24:0], 7'h13 ^ a[8:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold reset over one edge, check reset outputs, then resynchronise the model.
    task automatic do_reset();
        RESET_N = 1'b0; FLUSH = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0;
        INSTR_READY = 1'b0; IMEM_RDATA = 32'h0;
        @(posedge CLK); #1;
        chk("rst_req", IMEM_REQ, 1'b0);
        chk("rst_adv", FETCH_ADV, 1'b0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_pc", INSTR_PC, 32'h0);
        chk("rst_op", OP, 7'b0010011);
        RESET_N = 1'b1;
        gq.delete(); exp_q.delete(); draining = 1'b0; drop_n = 0;
    endtask

    // Drive one cycle, check all outputs against the model, then step the model.
    task automatic cyc(input logic gnt, input logic rv, input logic rdy, input logic fl);
        logic        exp_req, rv_eff, granted, popped, was_drain, exp_valid;
        logic [31:0] ip_now, a;
        logic [63:0] e;
        rv_eff = rv && (gq.size() > 0);
        IMEM_GNT = gnt; IMEM_RVALID = rv_eff; INSTR_READY = rdy; FLUSH = fl;
        IMEM_RDATA = rv_eff ? word_of(gq[0]) : 32'h0;
        #1;
        exp_req   = !draining && !fl && ((exp_q.size() + gq.size()) < DEPTH);
        exp_valid = !draining && (exp_q.size() > 0);
        chk("imem_req", IMEM_REQ, exp_req);
        chk("fetch_adv", FETCH_ADV, exp_req && gnt);
        chk("imem_addr", IMEM_ADDR, IP);
        chk("instr_valid", INSTR_VALID, exp_valid);
        if (exp_valid) begin
            e = exp_q[0];
            chk("instr", INSTR, e[31:0]);
            chk("instr_pc", INSTR_PC, e[63:32]);
            chk("op", OP, e[6:0]);
        end else begin
            chk("op_nop", OP, 7'b0010011);
        end
        if (FETCH_ADV === 1'b1) adv_cnt++;
        granted   = exp_req && gnt;
        popped    = exp_valid && rdy && !fl;
        was_drain = draining;
        ip_now    = IP;
        if (popped) pc_log.push_back(INSTR_PC);
        @(posedge CLK); #1;
        if (popped) void'(exp_q.pop_front());
        if (rv_eff) begin
            a = gq.pop_front();
            if (was_drain) drop_n--;
            else if (!fl) exp_q.push_back({a, word_of(a)});
        end
        if (granted) begin
            gq.push_back(ip_now);
            IP = ip_now + 32'h4;
        end
        if (fl && !was_drain) begin
            exp_q.delete();
            if (gq.size() > 0) begin
                draining = 1'b1;
                drop_n = gq.size();
            end
        end
        if (was_drain && drop_n == 0) draining = 1'b0;
    endtask

    initial begin
        // Reset, then a single fetch of IP=0 returning 0x13
        do_reset();
        IP = 32'h0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("first_valid", INSTR_VALID, 1'b1);
        chk("first_instr", INSTR, 32'h0000_0013);
        chk("first_pc", INSTR_PC, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Decode stalled: exactly two grants, then requests stop
        IP = 32'h0; adv_before = adv_cnt;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("fill_grants", adv_cnt - adv_before, 2);
        chk("fill_head_pc", INSTR_PC, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // Flush with 0x8 and 0xC outstanding, drain, then fetch 0x100
        IP = 32'h8;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("drain_state", draining, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        IP = 32'h100;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("redir_pc", INSTR_PC, 32'h100);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Grant withheld five cycles at IP=0x20, then a single grant
        IP = 32'h20; adv_before = adv_cnt;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_no_adv", adv_cnt - adv_before, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("stall_one_adv", adv_cnt - adv_before, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Same-cycle response and pop keep order: PCs 0x0, 0x4, 0x8
        IP = 32'h0; pc_log.delete();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("order_len_ok", pc_log.size() >= 3, 1'b1);
        if (pc_log.size() >= 3) begin
            chk("order_pc0", pc_log[0], 32'h0);
            chk("order_pc1", pc_log[1], 32'h4);
            chk("order_pc2", pc_log[2], 32'h8);
        end

        // Reset with one request outstanding, then a clean fetch of 0x0
        IP = 32'h40;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        IP = 32'h0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_pc", INSTR_PC, 32'h0);
        chk("post_rst_instr", INSTR, 32'h0000_0013);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
